// File: rtl/seq_pkg.sv
// Shared definitions for the "0110" framed serial generator and its matching detector.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [3:0] HDR_PATTERN = 4'b0110;
  localparam int         HDR_LEN     = 4;
  localparam logic       IDLE_LEVEL  = 1'b1;

  // Header is sent MSB-first, so index 0 selects HDR_PATTERN[3].
  function automatic logic hdr_bit(input logic [1:0] idx);
    return HDR_PATTERN[2'd3 - idx];
  endfunction

endpackage

// File: rtl/seq_piso.sv
// DATA_W parallel-in serial-out shift register, MSB-first; o_msb always shows the next bit to send.
module seq_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_msb
);

  logic [DATA_W-1:0] r_sr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_din;
    end else if (i_shift) begin
      r_sr <= r_sr << 1;
    end
  end

  assign o_msb = r_sr[DATA_W-1];

endmodule

// File: rtl/seq_generator.sv
// Framed serial transmitter: header 0110, payload MSB-first, then an idle gap.
// Optional even-parity bit after the payload when SEQ_GEN_PARITY_EN is defined.
module seq_generator
  import seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
`ifdef SEQ_GEN_PARITY_EN
  localparam int DATA_LEN = DATA_W + 1;
`else
  localparam int DATA_LEN = DATA_W;
`endif

  state_t             r_state;
  logic [1:0]         r_hdr_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_x;
  logic               r_x_valid;
  logic               r_busy;
  logic               r_frame_done;
`ifdef SEQ_GEN_PARITY_EN
  logic               r_parity;
`endif

  logic               w_accept;
  logic               w_shift;
  logic               w_msb;
  logic               w_data_next;
  logic [BIT_W-1:0]   w_bit_cnt_inc;

  assign w_accept      = din_valid && (r_state == IDLE);
  // The shifter advances each time its current MSB is copied into r_x.
  assign w_shift       = ((r_state == HDR) && (r_hdr_cnt == 2'd3)) || (r_state == DATA);
  assign w_bit_cnt_inc = r_bit_cnt + 1'b1;

`ifdef SEQ_GEN_PARITY_EN
  assign w_data_next = (r_bit_cnt == BIT_W'(DATA_W - 1)) ? r_parity : w_msb;
`else
  assign w_data_next = w_msb;
`endif

  seq_piso #(.DATA_W(DATA_W)) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_din   (din),
    .o_msb   (w_msb)
  );

  // Outputs are loaded one edge ahead, so r_x always holds the bit of the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hdr_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_x          <= IDLE_LEVEL;
      r_x_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= HDR;
            r_hdr_cnt <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_x       <= hdr_bit(2'd0);
            r_x_valid <= 1'b1;
            r_busy    <= 1'b1;
`ifdef SEQ_GEN_PARITY_EN
            r_parity  <= ^din;
`endif
          end
        end
        HDR: begin
          if (r_hdr_cnt == 2'(HDR_LEN - 1)) begin
            r_state      <= DATA;
            r_bit_cnt    <= '0;
            r_x          <= w_msb;
            r_frame_done <= (DATA_LEN == 1);
          end else begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            r_x       <= hdr_bit(r_hdr_cnt + 2'd1);
          end
        end
        DATA: begin
          if (r_bit_cnt == BIT_W'(DATA_LEN - 1)) begin
            r_state      <= GAP;
            r_gap_cnt    <= '0;
            r_x          <= IDLE_LEVEL;
            r_x_valid    <= 1'b0;
            r_frame_done <= 1'b0;
          end else begin
            r_bit_cnt    <= w_bit_cnt_inc;
            r_x          <= w_data_next;
            r_frame_done <= (w_bit_cnt_inc == BIT_W'(DATA_LEN - 1));
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            r_state   <= IDLE;
            r_hdr_cnt <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign din_ready  = (r_state == IDLE);
  assign x          = r_x;
  assign x_valid    = r_x_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seq_generator.sv
// Directed, table-driven bench for seq_generator (DATA_W=8, GAP_CYC=2); honours SEQ_GEN_PARITY_EN.
module tb_seq_generator;

`ifdef SEQ_GEN_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] din;
    logic       vld;
    logic       ex;
    logic       exv;
    logic       ebusy;
    logic       efd;
    logic       erdy;
  } vec_t;

  vec_t tbl[$];
  logic xs[$];
  logic fds[$];

  seq_generator #(.DATA_W(8), .GAP_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x"},     32'(x),          32'd1);
    check({tag, "_xv"},    32'(x_valid),    32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_fd"},    32'(frame_done), 32'd0);
    check({tag, "_ready"}, 32'(din_ready),  32'd1);
  endtask

  task automatic push(input logic [7:0] d, input logic v, input logic ex, input logic exv,
                      input logic eb, input logic efd, input logic er);
    vec_t e;
    e.din = d; e.vld = v; e.ex = ex; e.exv = exv; e.ebusy = eb; e.efd = efd; e.erdy = er;
    tbl.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Offer w on step 0, then drive mid_din/mid_valid for the rest of the frame.
  task automatic push_frame(input logic [7:0] w, input logic [7:0] mid_din, input logic mid_valid);
    logic [3:0] hdr;
    hdr = 4'b0110;
    push(w, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 3; i >= 0; i--) push(mid_din, mid_valid, hdr[i], 1'b1, 1'b1, 1'b0, 1'b0);
    for (int j = 7; j >= 0; j--)
      push(mid_din, mid_valid, w[j], 1'b1, 1'b1, (j == 0) && !PAR, 1'b0);
    if (PAR) push(mid_din, mid_valid, ^w, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 2; g++) push(mid_din, mid_valid, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic apply(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      din       = tbl[i].din;
      din_valid = tbl[i].vld;
      #1;
      check($sformatf("%s[%0d]_x", tag, i),     32'(x),          32'(tbl[i].ex));
      check($sformatf("%s[%0d]_xv", tag, i),    32'(x_valid),    32'(tbl[i].exv));
      check($sformatf("%s[%0d]_busy", tag, i),  32'(busy),       32'(tbl[i].ebusy));
      check($sformatf("%s[%0d]_fd", tag, i),    32'(frame_done), 32'(tbl[i].efd));
      check($sformatf("%s[%0d]_ready", tag, i), 32'(din_ready),  32'(tbl[i].erdy));
      xs.push_back(x);
      fds.push_back(frame_done);
    end
    tbl.delete();
  endtask

  initial begin
    logic [11:0] a5_bits;
    logic [11:0] a5_exp;
    int          z_cnt;
    int          z_idx;

    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    #12;
    check_idle("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    push_idle(10);
    apply("idle");

    // A5 frame: header + payload on cycles 1..12, gap on 13-14, ready again on 15.
    xs.delete(); fds.delete();
    push_frame(8'hA5, 8'h5A, 1'b0);
    push_idle(1);
    apply("a5");
    a5_exp = 12'b0110_1010_0101;
    for (int i = 0; i < 12; i++) a5_bits[11-i] = xs[i+1];
    check("a5_serial_bits", 32'(a5_bits), 32'(a5_exp));
    check("a5_fd_cycle12", 32'(fds[12]), 32'd1);

    // Loopback: an overlapping 0110 detector on x must fire only on cycle 4.
    xs.delete(); fds.delete();
    push_frame(8'hFF, 8'h00, 1'b0);
    push_idle(1);
    apply("loop");
    z_cnt = 0;
    z_idx = -1;
    for (int i = 3; i < xs.size(); i++) begin
      if ({xs[i-3], xs[i-2], xs[i-1], xs[i]} == 4'b0110) begin
        z_cnt++;
        if (z_idx < 0) z_idx = i;
      end
    end
    check("loop_z_count", 32'(z_cnt), 32'd1);
    check("loop_z_cycle", 32'(z_idx), 32'd4);

    // Back-to-back with din_valid held; 3C offered during frame 1 must not leak in.
    push_frame(8'h00, 8'h3C, 1'b1);
    push_frame(8'h3C, 8'h00, 1'b0);
    push_idle(2);
    apply("b2b");

    // Async reset at cycle 6 of a frame.
    @(negedge clk);
    din = 8'hC3; din_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
    end
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_xv",   32'(x_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    check_idle("rst_held");
    rst_n = 1'b1;
    push_idle(2);
    push_frame(8'hC3, 8'hFF, 1'b0);
    push_idle(1);
    apply("post_rst");

`ifdef SEQ_GEN_PARITY_EN
    xs.delete(); fds.delete();
    push_frame(8'h07, 8'h00, 1'b0);
    push_idle(1);
    apply("par");
    check("par_bit",     32'(xs[13]),  32'd1);
    check("par_fd",      32'(fds[13]), 32'd1);
    check("par_no_fd12", 32'(fds[12]), 32'd0);
    check("par_ready16", 32'(xs.size()), 32'd17);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
